// File: rtl/wb_dma_sequencer_if.sv
// Wishbone classic bus bundle between wb_dma_sequencer (master) and the
// wb_stream_writer configuration port (slave).
interface wb_dma_sequencer_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_dma_sequencer.sv
// wb_dma_sequencer: programs wb_stream_writer one packet per pass
// (START_ADDR, BUF_SIZE, BURST_SIZE, ENABLE), waits for its interrupt,
// clears it, advances the packet address and repeats.
// Optional build macro DMA_SEQ_WRAP_EN: the ring wraps to packet 0 after
// NUM_PACKETS-1 and the run continues until stop or bus error.
module wb_dma_sequencer #(
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned PACKET_SIZE = 170,
  parameter int unsigned BURST_SIZE  = 34,
  parameter int unsigned NUM_PACKETS = 100,
  parameter int unsigned WSB         = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       irq_i,
  wb_dma_sequencer_if.master         wbm,
  output logic                       busy_o,
  output logic [15:0]                pkt_idx_o,
  output logic                       pkt_done_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam logic [31:0] ADR_ENABLE = 32'(0);
  localparam logic [31:0] ADR_START  = 32'(WSB);
  localparam logic [31:0] ADR_BUF    = 32'(2 * WSB);
  localparam logic [31:0] ADR_BURST  = 32'(3 * WSB);
  localparam logic [31:0] DAT_SIZE   = 32'(PACKET_SIZE * 4);
  localparam logic [31:0] DAT_BURST  = 32'(BURST_SIZE);
  localparam logic [31:0] DAT_EN     = 32'd1;
  localparam logic [31:0] DAT_CLR    = 32'd2;
  localparam logic [31:0] ADDR_BASE  = 32'(BASE_ADDR);
  localparam logic [31:0] ADDR_STEP  = 32'(PACKET_SIZE * WSB);
  localparam logic [15:0] LAST_IDX   = 16'(NUM_PACKETS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_SIZE,
    S_WR_BURST,
    S_WR_EN,
    S_WAIT_IRQ,
    S_WR_CLR,
    S_NEXT
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] addr_acc_q, addr_acc_d;
  logic [15:0] pkt_idx_q, pkt_idx_d;
  logic        stop_pend_q, stop_pend_d;
  logic        busy_q, busy_d;
  logic        pkt_done_q, pkt_done_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [31:0] wr_adr;
  logic [31:0] wr_dat;
  state_t      after_state;
  logic [31:0] next_addr;
  logic        last_pkt;
  logic        end_run;
  logic        dat_r_unused;

  assign dat_r_unused = ^wbm.dat_r;

  // Register address, data and successor for the write owned by each state.
  always_comb begin
    wr_adr      = ADR_START;
    wr_dat      = addr_acc_q;
    after_state = S_WR_SIZE;
    case (state_q)
      S_WR_SIZE:  begin wr_adr = ADR_BUF;    wr_dat = DAT_SIZE;  after_state = S_WR_BURST; end
      S_WR_BURST: begin wr_adr = ADR_BURST;  wr_dat = DAT_BURST; after_state = S_WR_EN;    end
      S_WR_EN:    begin wr_adr = ADR_ENABLE; wr_dat = DAT_EN;    after_state = S_WAIT_IRQ; end
      S_WR_CLR:   begin wr_adr = ADR_ENABLE; wr_dat = DAT_CLR;   after_state = S_NEXT;     end
      default:    ;
    endcase
  end

  // Sequencer next-state logic. A write state with cyc low issues its
  // write (this is the single idle bus cycle after the previous ack);
  // IDLE, WAIT_IRQ and NEXT issue the following write directly so the
  // gap between writes never exceeds one cycle.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    addr_acc_d  = addr_acc_q;
    pkt_idx_d   = pkt_idx_q;
    stop_pend_d = stop_pend_q | (stop_i & (state_q != S_IDLE));
    err_d       = err_q;
    pkt_done_d  = 1'b0;
    done_d      = 1'b0;
    next_addr   = addr_acc_q + ADDR_STEP;
    last_pkt    = (pkt_idx_q == LAST_IDX);
    end_run     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_WR_ADDR;
          cyc_d       = 1'b1;
          adr_d       = ADR_START;
          dat_d       = ADDR_BASE;
          addr_acc_d  = ADDR_BASE;
          pkt_idx_d   = '0;
          err_d       = 1'b0;
          stop_pend_d = stop_i;
        end
      end

      S_WR_ADDR, S_WR_SIZE, S_WR_BURST, S_WR_EN, S_WR_CLR: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
          adr_d = wr_adr;
          dat_d = wr_dat;
        end else if (wbm.err) begin
          state_d     = S_IDLE;
          cyc_d       = 1'b0;
          err_d       = 1'b1;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else if (wbm.ack) begin
          cyc_d   = 1'b0;
          state_d = after_state;
        end
      end

      S_WAIT_IRQ: begin
        if (irq_i) begin
          state_d = S_WR_CLR;
          cyc_d   = 1'b1;
          adr_d   = ADR_ENABLE;
          dat_d   = DAT_CLR;
        end
      end

      S_NEXT: begin
        pkt_done_d = 1'b1;
`ifdef DMA_SEQ_WRAP_EN
        if (last_pkt) begin
          pkt_idx_d  = '0;
          addr_acc_d = ADDR_BASE;
        end else begin
          pkt_idx_d  = pkt_idx_q + 16'd1;
          addr_acc_d = next_addr;
        end
        end_run = stop_pend_q;
`else
        if (!last_pkt) begin
          pkt_idx_d  = pkt_idx_q + 16'd1;
          addr_acc_d = next_addr;
        end
        end_run = last_pkt | stop_pend_q;
`endif
        if (end_run) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else begin
          state_d = S_WR_ADDR;
          cyc_d   = 1'b1;
          adr_d   = ADR_START;
          dat_d   = addr_acc_d;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; asynchronous reset clears the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      addr_acc_q  <= '0;
      pkt_idx_q   <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      pkt_done_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      addr_acc_q  <= addr_acc_d;
      pkt_idx_q   <= pkt_idx_d;
      stop_pend_q <= stop_pend_d;
      busy_q      <= busy_d;
      pkt_done_q  <= pkt_done_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign wbm.adr    = adr_q;
  assign wbm.dat_w  = dat_q;
  assign wbm.cyc    = cyc_q;
  assign wbm.stb    = cyc_q;
  assign wbm.we     = cyc_q;
  assign wbm.sel    = 4'hf;
  assign wbm.cti    = 3'b000;
  assign wbm.bte    = 2'b00;

  assign busy_o     = busy_q;
  assign pkt_idx_o  = pkt_idx_q;
  assign pkt_done_o = pkt_done_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_wb_dma_sequencer.sv
// Scoreboard bench for wb_dma_sequencer: expected register writes are queued
// per run from a packet-level model; a monitor pops them on every ack.
module tb_wb_dma_sequencer;

  localparam int unsigned BASE_ADDR   = 0;
  localparam int unsigned PACKET_SIZE = 170;
  localparam int unsigned BURST_SIZE  = 34;
  localparam int unsigned NUM_PACKETS = 100;
  localparam int unsigned WSB         = 4;
`ifdef DMA_SEQ_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_i;
  logic        stop_main;
  logic        stop_irq;
  logic        stop_i;
  logic        irq_i;
  logic        busy_o;
  logic [15:0] pkt_idx_o;
  logic        pkt_done_o;
  logic        done_o;
  logic        err_o;

  assign stop_i = stop_main | stop_irq;

  wb_dma_sequencer_if bus ();

  wb_dma_sequencer #(
    .BASE_ADDR  (BASE_ADDR),
    .PACKET_SIZE(PACKET_SIZE),
    .BURST_SIZE (BURST_SIZE),
    .NUM_PACKETS(NUM_PACKETS),
    .WSB        (WSB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .irq_i     (irq_i),
    .wbm       (bus),
    .busy_o    (busy_o),
    .pkt_idx_o (pkt_idx_o),
    .pkt_done_o(pkt_done_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;
  wr_t exp_q[$];

  // ---------------- slave with random wait states and error injection
  int unsigned max_dly = 0;
  int unsigned dly     = 0;
  int unsigned wcnt    = 0;
  int          xfer_cnt = 0;
  int          err_at   = -1;
  logic        rdy;

  assign rdy       = bus.cyc && bus.stb && (wcnt >= dly);
  assign bus.ack   = rdy && (xfer_cnt != err_at);
  assign bus.err   = rdy && (xfer_cnt == err_at);
  assign bus.dat_r = '0;

  always @(posedge clk) begin
    if (bus.cyc && bus.stb) begin
      if (rdy) begin
        wcnt     <= 0;
        dly      <= $urandom_range(0, max_dly);
        xfer_cnt <= xfer_cnt + 1;
      end else begin
        wcnt <= wcnt + 1;
      end
    end
  end

  // ---------------- interrupt model of the stream writer
  int  en_cnt    = 0;
  int  stop_abs  = -1;
  bit  irq_fixed = 1'b1;

  initial begin
    int cd;
    int drop;
    cd = -1;
    drop = -1;
    irq_i = 1'b0;
    stop_irq = 1'b0;
    forever begin
      @(negedge clk);
      stop_irq = 1'b0;
      if (bus.cyc && bus.stb && bus.ack && bus.adr == 0 && bus.dat_w == 1) begin
        en_cnt++;
        cd = irq_fixed ? 20 : int'($urandom_range(8, 30));
      end else if (cd > 0) begin
        cd--;
        if (cd == 3 && en_cnt - 1 == stop_abs) stop_irq = 1'b1;
        if (cd == 0) irq_i = 1'b1;
      end
      if (bus.cyc && bus.stb && bus.ack && bus.adr == 0 && bus.dat_w == 2) begin
        drop = int'($urandom_range(1, 4));
      end else if (drop > 0) begin
        drop--;
        if (drop == 0) irq_i = 1'b0;
      end
    end
  end

  // ---------------- monitor
  int          done_cnt     = 0;
  int          pkt_done_cnt = 0;
  logic [15:0] idx_at_done  = '0;
  logic        pd_with_done = 1'b0;

  initial begin
    bit          prev_pend;
    bit          prev_cyc;
    bit          seen_wr;
    bit          last_en;
    int          low_cnt;
    logic [31:0] prev_adr;
    logic [31:0] prev_dat;
    wr_t         e;
    prev_pend = 0; prev_cyc = 0; seen_wr = 0; last_en = 0; low_cnt = 0;
    prev_adr = '0; prev_dat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 0; prev_cyc = 0; seen_wr = 0; low_cnt = 0;
      end else begin
        if (prev_pend) begin
          chk("hold_cyc_stb", 32'({bus.cyc, bus.stb}), 32'd3);
          chk("hold_adr", bus.adr, prev_adr);
          chk("hold_dat", bus.dat_w, prev_dat);
        end
        if (!busy_o && !bus.cyc) seen_wr = 0;
        if (bus.cyc && !prev_cyc && seen_wr && !last_en)
          chk("gap_cycles", 32'(low_cnt), 32'd1);
        if (!bus.cyc) low_cnt++;
        if (bus.cyc && bus.stb && bus.ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_write: got adr 0x%08h dat 0x%08h, required no write",
                     bus.adr, bus.dat_w);
          end else begin
            e = exp_q.pop_front();
            chk("wr_adr", bus.adr, e.adr);
            chk("wr_dat", bus.dat_w, e.dat);
            chk("wr_we_sel", 32'({bus.we, bus.sel}), 32'h1f);
          end
        end
        if (bus.cyc && bus.stb && (bus.ack || bus.err)) begin
          seen_wr = 1;
          last_en = (bus.adr == 0 && bus.dat_w == 1);
          low_cnt = 0;
        end
        prev_pend = bus.cyc && bus.stb && !bus.ack && !bus.err;
        prev_adr  = bus.adr;
        prev_dat  = bus.dat_w;
        prev_cyc  = bus.cyc;
        if (done_o) begin
          done_cnt++;
          idx_at_done  = pkt_idx_o;
          pd_with_done = pkt_done_o;
        end
        if (pkt_done_o) pkt_done_cnt++;
      end
    end
  end

  // ---------------- reference model: writes for packet k of a run
  function automatic logic [31:0] pkt_addr(input int k);
    longint unsigned slot;
    slot = WRAP ? longint'(k % NUM_PACKETS) : longint'(k);
    return 32'(longint'(BASE_ADDR) + slot * PACKET_SIZE * WSB);
  endfunction

  task automatic push_pkt(input int k);
    exp_q.push_back('{32'(WSB),     pkt_addr(k)});
    exp_q.push_back('{32'(2 * WSB), 32'(PACKET_SIZE * 4)});
    exp_q.push_back('{32'(3 * WSB), 32'(BURST_SIZE)});
    exp_q.push_back('{32'd0,        32'd1});
    exp_q.push_back('{32'd0,        32'd2});
  endtask

  // stop_rel < 0: no stop requested
  task automatic model_run(input int stop_rel, output int npk, output int fidx);
    if (stop_rel < 0 || (!WRAP && stop_rel >= int'(NUM_PACKETS) - 1)) begin
      npk  = NUM_PACKETS;
      fidx = NUM_PACKETS - 1;
    end else begin
      npk  = stop_rel + 1;
      fidx = WRAP ? (stop_rel + 1) % int'(NUM_PACKETS) : stop_rel + 1;
    end
    for (int k = 0; k < npk; k++) push_pkt(k);
  endtask

  task automatic pulse_start(input bit with_stop);
    @(negedge clk);
    start_i   = 1'b1;
    stop_main = with_stop;
    @(negedge clk);
    start_i   = 1'b0;
    stop_main = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 40000 && done_cnt == d0; i++) @(negedge clk);
  endtask

  task automatic run_and_check(input string tag, input int stop_rel, input bit stop_with_start);
    int npk, fidx, d0, p0;
    model_run(stop_rel, npk, fidx);
    d0 = done_cnt;
    p0 = pkt_done_cnt;
    if (stop_rel >= 0 && !stop_with_start) stop_abs = en_cnt + stop_rel;
    pulse_start(stop_with_start);
    chk({tag, "_busy_after_start"}, 32'(busy_o), 32'd1);
    chk({tag, "_err_after_start"}, 32'(err_o), 32'd0);
    wait_done(d0);
    repeat (40) @(negedge clk);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_pkt_done_pulses"}, 32'(pkt_done_cnt - p0), 32'(npk));
    chk({tag, "_idx_at_done"}, 32'(idx_at_done), 32'(fidx));
    chk({tag, "_pkt_done_with_done"}, 32'(pd_with_done), 32'd1);
    chk({tag, "_idx_hold"}, 32'(pkt_idx_o), 32'(fidx));
    chk({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    chk({tag, "_cyc_end"}, 32'(bus.cyc), 32'd0);
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    stop_abs = -1;
  endtask

  initial begin
    int d0, p0;
    rst_n = 1'b0;
    start_i = 1'b0;
    stop_main = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cyc_stb_we", 32'({bus.cyc, bus.stb, bus.we}), 32'd0);
    chk("rst_adr", bus.adr, 32'd0);
    chk("rst_dat", bus.dat_w, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_idx", 32'(pkt_idx_o), 32'd0);
    chk("rst_pulses_err", 32'({pkt_done_o, done_o, err_o}), 32'd0);
    chk("const_sel_cti_bte", 32'({bus.sel, bus.cti, bus.bte}), 32'h1e0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full run, zero-wait slave, interrupt 20 clocks after ENABLE
    max_dly = 0;
    irq_fixed = 1'b1;
    if (WRAP) run_and_check("full", int'(NUM_PACKETS) + 2, 1'b0);
    else      run_and_check("full", -1, 1'b0);

    // random wait states and interrupt latency from here on
    max_dly = 5;
    irq_fixed = 1'b0;
    run_and_check("stop3", 3, 1'b0);
    run_and_check("stop9", 9, 1'b0);
    run_and_check("start_stop", 0, 1'b1);

    // bus error on BUF_SIZE write of packet 2 (transfer index 11)
    push_pkt(0);
    push_pkt(1);
    exp_q.push_back('{32'(WSB), pkt_addr(2)});
    err_at = xfer_cnt + 11;
    d0 = done_cnt;
    p0 = pkt_done_cnt;
    pulse_start(1'b0);
    wait_done(d0);
    repeat (10) @(negedge clk);
    chk("err_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("err_flag", 32'(err_o), 32'd1);
    chk("err_busy", 32'(busy_o), 32'd0);
    chk("err_cyc", 32'(bus.cyc), 32'd0);
    chk("err_pkt_done_pulses", 32'(pkt_done_cnt - p0), 32'd2);
    chk("err_idx", 32'(pkt_idx_o), 32'd2);
    chk("err_writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    err_at = -1;

    // restart after error clears err_o and begins at BASE_ADDR
    run_and_check("restart", 0, 1'b0);

    // asynchronous reset in the middle of a write
    push_pkt(0);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("mid_cyc_before_rst", 32'(bus.cyc), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc_stb_we", 32'({bus.cyc, bus.stb, bus.we}), 32'd0);
    chk("arst_adr", bus.adr, 32'd0);
    chk("arst_dat", bus.dat_w, 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_idx_pulses_err", 32'({pkt_idx_o, pkt_done_o, done_o, err_o}), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
